// File: rtl/fractcam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fractcam_pkg
// Description : Shared types, constants and helpers for the fractured TCAM
//               LUTRAM write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fractcam_pkg;

  // Every LUTRAM search slice is a 64x1 primitive addressed by one 6-bit chunk
  localparam int LUT_ADDR_W = 6;
  localparam int CHUNK_W    = 6;
  localparam int LUT_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  // Number of 6-bit key chunks, rounding up so a partial top chunk is kept
  function automatic int n_chunk(input int key_width);
    return (key_width + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fractcam_chunk_match.sv
`default_nettype none
// ============================================================================
// Module      : fractcam_chunk_match
// Description : Ternary compare of one LUTRAM address against one key chunk.
//               Output is 1 when the address agrees with the key on every
//               bit whose mask bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module fractcam_chunk_match
  import fractcam_pkg::*;
(
  input  logic [CHUNK_W-1:0] addr_i,
  input  logic [CHUNK_W-1:0] key_i,
  input  logic [CHUNK_W-1:0] mask_i,
  output logic               match_o
);

  assign match_o = (((addr_i ^ key_i) & mask_i) == '0);

endmodule
`default_nettype wire

// File: rtl/fractcam_lutram_wr.sv
`default_nettype none
// ============================================================================
// Module      : fractcam_lutram_wr
// Description : Write/update engine for the fractured TCAM search array.
//               Expands one ternary rule (key, care-mask) into the 64-entry
//               LUTRAM contents of one TCAM entry column, one address per
//               cycle, and stalls search while the column is inconsistent.
//               Optional feature macro: FRACTCAM_WR_DELETE_EN
//               (when defined, wr_del=1 writes an entry that never matches).
// Revision    : 1.0 - initial release
// ============================================================================
module fractcam_lutram_wr
  import fractcam_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int KEY_WIDTH = 36,
  parameter int IDX_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [IDX_WIDTH-1:0]          wr_idx,
  input  logic [KEY_WIDTH-1:0]          wr_key,
  input  logic [KEY_WIDTH-1:0]          wr_mask,
  input  logic                          wr_del,
  output logic                          lut_we,
  output logic [LUT_ADDR_W-1:0]         lut_waddr,
  output logic [DEPTH-1:0]              lut_wsel,
  output logic [n_chunk(KEY_WIDTH)-1:0] lut_wdata,
  output logic                          search_stall,
  output logic                          wr_done
);

  localparam int N_CHUNK = n_chunk(KEY_WIDTH);
  localparam int PAD_W   = N_CHUNK * CHUNK_W;

  wr_state_e               state_q;
  logic [LUT_ADDR_W-1:0]   cnt_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [KEY_WIDTH-1:0]    mask_q;
  logic                    we_q;
  logic                    done_q;
  logic                    stall_q;
  logic                    del_q;

  logic [PAD_W-1:0]        key_pad;
  logic [PAD_W-1:0]        mask_pad;
  logic [N_CHUNK-1:0]      chunk_match;
  logic                    accept;

`ifdef FRACTCAM_WR_DELETE_EN
  logic                    del_in;
  assign del_in = wr_del;
`else
  logic                    del_in;
  logic                    unused_del;
  assign del_in     = 1'b0;
  assign unused_del = wr_del;
`endif

  // Ready is decoded so it drops with reset and rises as soon as reset is released
  assign wr_ready = rst_n && (state_q == ST_IDLE);
  assign accept   = wr_valid && (state_q == ST_IDLE);

  // Control FSM: capture the rule, sweep all 64 LUT addresses, then pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      mask_q  <= '0;
      del_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= wr_idx;
            key_q   <= wr_key;
            mask_q  <= wr_mask;
            del_q   <= del_in;
            cnt_q   <= '0;
            we_q    <= 1'b1;
            stall_q <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Single pass only: leave WRITE after the last address
          if (cnt_q == LUT_ADDR_W'(LUT_DEPTH - 1)) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          stall_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Padding bits above KEY_WIDTH get a zero mask, i.e. they are don't-care
  assign key_pad  = PAD_W'(key_q);
  assign mask_pad = PAD_W'(mask_q);

  generate
    for (genvar c = 0; c < N_CHUNK; c++) begin : g_chunk
      fractcam_chunk_match u_match (
        .addr_i  (cnt_q),
        .key_i   (key_pad[c*CHUNK_W +: CHUNK_W]),
        .mask_i  (mask_pad[c*CHUNK_W +: CHUNK_W]),
        .match_o (chunk_match[c])
      );
    end
  endgenerate

  // Column select; an out-of-range index selects no column at all
  always_comb begin
    lut_wsel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (we_q && (idx_q == IDX_WIDTH'(i))) begin
        lut_wsel[i] = 1'b1;
      end
    end
  end

  assign lut_we       = we_q;
  assign lut_waddr    = cnt_q;
  assign lut_wdata    = (we_q && !del_q) ? chunk_match : '0;
  assign search_stall = stall_q;
  assign wr_done      = done_q;

endmodule
`default_nettype wire
